div_unit: RTL
=============

DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL provide one clock; reset is asynchronous and active-low.
REQ-002 clk_i  input  1  pipeline clock; all state updates on rising edge.
REQ-003 rst_i  input  1  asynchronous active-low reset.
REQ-004 start_i  input  1  EX holds high while a DIV/DIVU occupies EX.
REQ-005 signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start_i.
REQ-006 dividend_i  input  32  rs operand; sampled at start acceptance.
REQ-007 divisor_i  input  32  rt operand; sampled at start acceptance.
REQ-008 cancel_i  input  1  exception flush; aborts any division.
REQ-009 ack_i  input  1  downstream advancing (no inst/data stall); consumes DONE result.
REQ-010 ex_ok_o  output  1  0 = division in progress; drives the stall controller's ex_ok_i.
REQ-011 lo_o  output  32  quotient.
REQ-012 hi_o  output  32  remainder.
REQ-013 busy_o  output  1  state == BUSY.

Function
REQ-014 FSM states SHALL be IDLE, BUSY, DONE.
REQ-015 IDLE: start_i=1 and cancel_i=0 SHALL latch operands; divisor != 0 -> BUSY, counter=0; divisor == 0 -> DONE.
REQ-016 BUSY SHALL perform one restoring shift-subtract step per cycle on absolute operand values, 32 steps, counter 0..31.
REQ-017 BUSY with counter == 31 SHALL apply sign fix-up, write lo_o/hi_o, go DONE.
REQ-018 Latency: start accepted cycle N; DONE in cycle N+33; ex_ok_o low cycles N..N+32, high from N+33.
REQ-019 ex_ok_o SHALL be 0 when state==BUSY, or state==IDLE with start_i=1 and cancel_i=0; otherwise 1 (combinational).
REQ-020 ex_ok_o SHALL be 1 whenever cancel_i=1.
REQ-021 DONE: ack_i=1 -> IDLE next cycle; ack_i=0 -> remain DONE, lo_o/hi_o stable.
REQ-022 Signed: quotient negated iff operand signs differ; remainder takes dividend sign.
REQ-023 0x80000000 / 0xFFFFFFFF signed SHALL give lo=0x80000000, hi=0 (wrap, no trap).
REQ-024 Divide-by-zero (either mode): lo=0xFFFFFFFF, hi=dividend, DONE one cycle after acceptance.
REQ-025 cancel_i=1 in any state SHALL force IDLE next cycle; lo_o/hi_o not updated by aborted op.
REQ-026 cancel_i and start_i simultaneous in IDLE: cancel wins, no start.
REQ-027 Back-to-back divisions: DONE+ack -> IDLE -> new start accepted next cycle.

Reset
REQ-028 rst_i low SHALL force state IDLE, counter 0, lo_o=0, hi_o=0, busy_o=0, internal operand/partial-remainder regs 0, at any time including mid-BUSY.
REQ-029 After reset release, ex_ok_o SHALL follow REQ-019 (1 if start_i=0).

Structure
REQ-030 div_state_e enum and DIV_CYCLES=32 SHALL live in the shared CPU package.
REQ-031 One combinational sub-module div_step SHALL implement one shift-compare-subtract iteration (33-bit partial remainder in, quotient bit + new remainder out).
REQ-032 Sign handling and FSM SHALL remain in div_unit; target 150-250 RTL lines.

Verification
REQ-033 DIVU 100/7 -> ex_ok_o low 33 cycles, then lo=14, hi=2.
REQ-034 DIV -7/2 (0xFFFFFFF9/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-035 DIVU 5/0 -> DONE next cycle, lo=0xFFFFFFFF, hi=5.
REQ-036 Start 100/7, cancel_i pulse in BUSY cycle 10 -> IDLE next cycle, ex_ok_o=1, lo/hi keep prior values; rst_i low in BUSY cycle 20 -> all outputs 0 immediately.
REQ-037 DONE with ack_i=0 for 3 cycles -> results stable, ex_ok_o=1; then ack_i=1 with new start 9/3 -> second result lo=3, hi=0 after 33 further cycles.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the multi-cycle integer divider: FSM states,
// iteration count and a small sign helper.
package div_unit_pkg;

    localparam int DIV_CYCLES = 32;
    localparam int CNT_W      = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Two's complement negation when neg is set; also used to take magnitudes.
    function automatic logic [31:0] negate_if(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring division iteration: compare the shifted partial remainder
// against the divisor and subtract when it fits.
module div_step (
    input  logic [32:0] partial_rem,
    input  logic [31:0] divisor,
    output logic        quot_bit,
    output logic [31:0] new_rem
);

    logic [32:0] trial;

    // partial_rem < 2*divisor, so a non-negative trial always fits in 32 bits.
    always_comb begin
        trial    = partial_rem - {1'b0, divisor};
        quot_bit = ~trial[32];
        new_rem  = quot_bit ? trial[31:0] : partial_rem[31:0];
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle DIV/DIVU unit for the EX stage: 32 restoring steps on operand
// magnitudes, sign fix-up on the last step, result held until acknowledged.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        signed_i,
    input  logic [31:0] dividend_i,
    input  logic [31:0] divisor_i,
    input  logic        cancel_i,
    input  logic        ack_i,
    output logic        ex_ok_o,
    output logic [31:0] lo_o,
    output logic [31:0] hi_o,
    output logic        busy_o
);

    div_state_e       state;
    logic [CNT_W-1:0] count;
    logic [31:0]      quo;
    logic [31:0]      dvs;
    logic [31:0]      rem;
    logic             neg_q;
    logic             neg_r;

    logic             dvd_neg;
    logic             dvs_neg;
    logic             step_bit;
    logic [31:0]      step_rem;
    logic [31:0]      q_final;

    assign dvd_neg = signed_i & dividend_i[31];
    assign dvs_neg = signed_i & divisor_i[31];

    // quo starts as the dividend magnitude and fills with quotient bits from the right.
    div_step u_step (
        .partial_rem ({rem, quo[31]}),
        .divisor     (dvs),
        .quot_bit    (step_bit),
        .new_rem     (step_rem)
    );

    assign q_final = {quo[30:0], step_bit};

    // Handshake: start_i is held by EX while the op occupies it; ex_ok_o low
    // stalls the pipe until the result is ready; in DONE ack_i consumes the
    // result (the pipe advances) and the unit returns to IDLE. cancel_i
    // always releases the stall and aborts.
    assign ex_ok_o = cancel_i | ~((state == DIV_BUSY) | ((state == DIV_IDLE) & start_i));
    assign busy_o  = (state == DIV_BUSY);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= DIV_IDLE;
            count <= '0;
            quo   <= '0;
            dvs   <= '0;
            rem   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            lo_o  <= '0;
            hi_o  <= '0;
        end else if (cancel_i) begin
            state <= DIV_IDLE;
            count <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start_i) begin
                        if (divisor_i == 32'd0) begin
                            lo_o  <= 32'hFFFF_FFFF;
                            hi_o  <= dividend_i;
                            state <= DIV_DONE;
                        end else begin
                            quo   <= negate_if(dividend_i, dvd_neg);
                            dvs   <= negate_if(divisor_i, dvs_neg);
                            rem   <= '0;
                            neg_q <= dvd_neg ^ dvs_neg;
                            neg_r <= dvd_neg;
                            count <= '0;
                            state <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    quo   <= q_final;
                    rem   <= step_rem;
                    count <= count + 1'b1;
                    if (count == CNT_W'(DIV_CYCLES - 1)) begin
                        lo_o  <= negate_if(q_final, neg_q);
                        hi_o  <= negate_if(step_rem, neg_r);
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (ack_i) begin
                        state <= DIV_IDLE;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

endmodule
